// File: rtl/audio_i2s_io_pkg.sv
// Shared audio constants and the receive-side state encoding for the I2S slave port.
package audio_i2s_io_pkg;

  // Default sample width for ADC and DAC words.
  localparam int AUDIO_DW = 16;

  // Default number of bit clocks allowed in one LRCK half-frame before it counts as malformed.
  localparam int AUDIO_SLOT_MAX = 32;

  // Receive FSM: wait for framing, skip the I2S delay bit, shift the word, idle out the slot.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_DELAY = 2'd1,
    RX_SHIFT = 2'd2,
    RX_HOLD  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer for an asynchronous codec clock plus rise/fall strobes in the clk domain.
module i2s_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the input, then keep one more stage so edges are seen on the clean copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/audio_i2s_io.sv
// I2S slave codec port: receives the right-channel microphone word and transmits one speaker
// sample per frame, framed by the codec's BCLK/LRCK, with frame-error detection.
module audio_i2s_io
  import audio_i2s_io_pkg::*;
#(
  parameter int DW       = AUDIO_DW,
  parameter int SLOT_MAX = AUDIO_SLOT_MAX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bclk,
  input  logic                 lrck,
  input  logic                 adc_dat,
  output logic                 dac_dat,
  input  logic signed [DW-1:0] vn_speaker,
  output logic signed [DW-1:0] en_temp,
  output logic                 audio_rx_down,
  output logic                 frame_err
);

  localparam int BW = $clog2(DW + 1);
  localparam int SW = $clog2(SLOT_MAX + 1);
  localparam int TW = $clog2(DW + 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [SW-1:0] SLOT_END = SW'(SLOT_MAX);
  localparam logic [SW-1:0] SLOT_PRE = SW'(SLOT_MAX - 1);
  localparam logic [TW-1:0] TX_LAST  = TW'(DW);

  logic w_bclkRise;
  logic w_bclkFall;
  logic w_boundary;

  logic r_lrckMeta;
  logic r_lrckSync;
  logic r_adcMeta;
  logic r_adcSync;
  logic r_lrckLast;
  logic r_lrckValid;

  rx_state_t       r_state;
  rx_state_t       w_stateNext;
  logic [BW-1:0]   r_bitCnt;
  logic [BW-1:0]   w_bitCntNext;
  logic [DW-1:0]   r_rxShift;
  logic [DW-1:0]   w_rxShiftNext;
  logic            r_chan;
  logic            w_chanNext;
  logic [SW-1:0]   r_slotCnt;
  logic            w_errPulse;
  logic            w_wordDone;
  logic            r_wordPending;

  logic [DW-1:0]   r_frame;
  logic [DW-1:0]   r_txShift;
  logic [TW-1:0]   r_txCnt;

  i2s_sync_edge u_bclkSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bclk),
    .o_rise  (w_bclkRise),
    .o_fall  (w_bclkFall)
  );

  // Plain two-flop synchronizers for LRCK and ADC data; they are only read on BCLK edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrckMeta <= 1'b0;
      r_lrckSync <= 1'b0;
      r_adcMeta  <= 1'b0;
      r_adcSync  <= 1'b0;
    end else begin
      r_lrckMeta <= lrck;
      r_lrckSync <= r_lrckMeta;
      r_adcMeta  <= adc_dat;
      r_adcSync  <= r_adcMeta;
    end
  end

  // Track LRCK as seen on BCLK rises; the first rise after reset only primes the history so a
  // stale reset value can never fake a half-frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrckLast  <= 1'b0;
      r_lrckValid <= 1'b0;
    end else if (w_bclkRise) begin
      r_lrckLast  <= r_lrckSync;
      r_lrckValid <= 1'b1;
    end
  end

  assign w_boundary = w_bclkRise & r_lrckValid & (r_lrckSync != r_lrckLast);

  // Count BCLK rises since the last boundary, saturating so an overrun is flagged only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slotCnt <= '0;
    end else if (w_bclkRise) begin
      if (w_boundary) begin
        r_slotCnt <= '0;
      end else if (r_slotCnt != SLOT_END) begin
        r_slotCnt <= r_slotCnt + 1'b1;
      end
    end
  end

  // RX next-state: boundaries restart framing (a boundary mid-word is an error), an overlong
  // half-frame drops back to IDLE, otherwise skip the delay bit and shift DW bits MSB first.
  always_comb begin
    w_stateNext   = r_state;
    w_bitCntNext  = r_bitCnt;
    w_rxShiftNext = r_rxShift;
    w_chanNext    = r_chan;
    w_errPulse    = 1'b0;
    w_wordDone    = 1'b0;
    if (w_bclkRise) begin
      if (w_boundary) begin
        w_chanNext  = r_lrckSync;
        w_stateNext = RX_DELAY;
        if (r_state == RX_SHIFT) begin
          w_errPulse = 1'b1;
        end
      end else if ((r_state != RX_IDLE) && (r_slotCnt == SLOT_PRE)) begin
        w_errPulse  = 1'b1;
        w_stateNext = RX_IDLE;
      end else begin
        case (r_state)
          RX_DELAY: begin
            w_stateNext  = RX_SHIFT;
            w_bitCntNext = '0;
          end
          RX_SHIFT: begin
            w_rxShiftNext = {r_rxShift[DW-2:0], r_adcSync};
            w_bitCntNext  = r_bitCnt + 1'b1;
            if (r_bitCnt == BIT_LAST) begin
              w_stateNext = RX_HOLD;
              w_wordDone  = r_chan;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RX_IDLE;
      r_bitCnt  <= '0;
      r_rxShift <= '0;
      r_chan    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_bitCnt  <= w_bitCntNext;
      r_rxShift <= w_rxShiftNext;
      r_chan    <= w_chanNext;
    end
  end

  // Publish a completed right word one clk after it is shifted in; frame errors win any tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wordPending <= 1'b0;
      en_temp       <= '0;
      audio_rx_down <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      r_wordPending <= w_wordDone;
      frame_err     <= w_errPulse;
      audio_rx_down <= r_wordPending & ~w_errPulse;
      if (r_wordPending && !w_errPulse) begin
        en_temp <= r_rxShift;
      end
    end
  end

  // TX: latch the speaker sample at each left boundary, reload the shifter every boundary, and
  // drive one delay zero, DW data bits, then zeros on successive BCLK falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame   <= '0;
      r_txShift <= '0;
      r_txCnt   <= '0;
      dac_dat   <= 1'b0;
    end else if (w_boundary) begin
      r_txCnt <= '0;
      if (!r_lrckSync) begin
        r_frame   <= vn_speaker;
        r_txShift <= vn_speaker;
      end else begin
        r_txShift <= r_frame;
      end
    end else if (w_bclkFall) begin
      if (r_txCnt == '0) begin
        dac_dat <= 1'b0;
        r_txCnt <= r_txCnt + 1'b1;
      end else if (r_txCnt <= TX_LAST) begin
        dac_dat   <= r_txShift[DW-1];
        r_txShift <= {r_txShift[DW-2:0], 1'b0};
        r_txCnt   <= r_txCnt + 1'b1;
      end else begin
        dac_dat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_io.sv
// Directed bench for audio_i2s_io: a codec model drives BCLK = clk/16 slots and checks the
// received microphone words, the transmitted speaker bits and the frame-error behaviour.
module tb_audio_i2s_io;

  logic        clk;
  logic        rst_n;
  logic        bclk;
  logic        lrck;
  logic        adcDat;
  logic        dacDat;
  logic [15:0] vnSpeaker;
  logic [15:0] enTemp;
  logic        audioRxDown;
  logic        frameErr;

  int compCount = 0;
  int errCount  = 0;
  int rxHigh    = 0;
  int rxPulses  = 0;
  int errHigh   = 0;
  int errPulses = 0;
  int collide   = 0;
  logic rxPrev  = 1'b0;
  logic errPrev = 1'b0;
  int errAtRise [64];

  int p0;
  int e0;

  audio_i2s_io #(.DW(16), .SLOT_MAX(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bclk          (bclk),
    .lrck          (lrck),
    .adc_dat       (adcDat),
    .dac_dat       (dacDat),
    .vn_speaker    (vnSpeaker),
    .en_temp       (enTemp),
    .audio_rx_down (audioRxDown),
    .frame_err     (frameErr)
  );

  // System clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe pulses and their widths, sampled away from the active edge.
  always @(negedge clk) begin
    if (audioRxDown) rxHigh++;
    if (audioRxDown && !rxPrev) rxPulses++;
    if (frameErr) errHigh++;
    if (frameErr && !errPrev) errPulses++;
    if (audioRxDown && frameErr) collide++;
    rxPrev  = audioRxDown;
    errPrev = frameErr;
  end

  // One comparison: counted, and reported with tag, observed and expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Codec model for one half-frame of nBits BCLK periods. LRCK changes on the first fall, the
  // word sits on periods 2..17, and the DAC bit is checked just before every rise against the
  // word the DUT should be transmitting. Optionally changes vn_speaker at period changeAt.
  task automatic applyStimulus(input string tag, input logic ch, input logic [15:0] word,
                               input int nBits, input logic [15:0] txExp,
                               input int changeAt, input logic [15:0] newVn);
    int bitIdx;
    logic expBit;
    for (int j = 0; j < nBits; j++) begin
      bclk = 1'b0;
      if (j == 0) lrck = ch;
      bitIdx = 17 - j;
      adcDat = (j >= 2 && j <= 17) ? word[bitIdx[3:0]] : 1'b0;
      if (j == changeAt) vnSpeaker = newVn;
      repeat (8) @(negedge clk);
      expBit = (j >= 2 && j <= 17) ? txExp[bitIdx[3:0]] : 1'b0;
      checkOutput($sformatf("dac_%s_%0d", tag, j), {31'b0, dacDat}, {31'b0, expBit});
      bclk = 1'b1;
      repeat (8) @(negedge clk);
      if (j < 64) errAtRise[j] = errPulses;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bclk      = 1'b1;
    lrck      = 1'b0;
    adcDat    = 1'b0;
    vnSpeaker = 16'hA5C3;
    repeat (4) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_en_temp", {16'b0, enTemp}, 32'h0);
    checkOutput("rst_rx_down", {31'b0, audioRxDown}, 32'h0);
    checkOutput("rst_frame_err", {31'b0, frameErr}, 32'h0);
    checkOutput("rst_dac", {31'b0, dacDat}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Frame A: framing is only found at the first right boundary; nothing latched for TX yet.
    $display("[TB] first frame");
    p0 = rxPulses;
    applyStimulus("A_L", 1'b0, 16'h1234, 32, 16'h0000, -1, 16'h0);
    checkOutput("A_left_no_pulse", rxPulses, p0);
    applyStimulus("A_R", 1'b1, 16'h8001, 32, 16'h0000, -1, 16'h0);
    checkOutput("A_en_temp", {16'b0, enTemp}, 32'h8001);
    checkOutput("A_pulse", rxPulses, p0 + 1);

    // Frame B: A5C3 latched at the left boundary and sent in both halves.
    applyStimulus("B_L", 1'b0, 16'h1234, 32, 16'hA5C3, -1, 16'h0);
    checkOutput("B_left_no_pulse", rxPulses, p0 + 1);
    applyStimulus("B_R", 1'b1, 16'h8001, 32, 16'hA5C3, -1, 16'h0);
    checkOutput("B_en_temp", {16'b0, enTemp}, 32'h8001);
    checkOutput("B_pulse", rxPulses, p0 + 2);

    // Frame C: speaker sample changes mid left slot; this frame still sends A5C3.
    $display("[TB] mid-frame speaker change");
    applyStimulus("C_L", 1'b0, 16'h1234, 32, 16'hA5C3, 5, 16'h0F0F);
    applyStimulus("C_R", 1'b1, 16'h3C5A, 32, 16'hA5C3, -1, 16'h0);
    checkOutput("C_en_temp", {16'b0, enTemp}, 32'h3C5A);
    checkOutput("C_pulse", rxPulses, p0 + 3);

    // Frame D: the new sample goes out.
    applyStimulus("D_L", 1'b0, 16'h1234, 32, 16'h0F0F, -1, 16'h0);
    applyStimulus("D_R", 1'b1, 16'h8001, 32, 16'h0F0F, -1, 16'h0);
    checkOutput("D_en_temp", {16'b0, enTemp}, 32'h8001);
    checkOutput("D_pulse", rxPulses, p0 + 4);

    // Frame E: right slot truncated to 10 BCLKs; error at the next boundary, word dropped.
    $display("[TB] truncated right slot");
    e0 = errPulses;
    applyStimulus("E_L", 1'b0, 16'h1234, 32, 16'h0F0F, -1, 16'h0);
    applyStimulus("E_R", 1'b1, 16'h5555, 10, 16'h0F0F, -1, 16'h0);
    applyStimulus("F_L", 1'b0, 16'h1234, 32, 16'h0F0F, -1, 16'h0);
    checkOutput("E_frame_err", errPulses, e0 + 1);
    checkOutput("E_no_pulse", rxPulses, p0 + 4);
    checkOutput("E_en_temp_kept", {16'b0, enTemp}, 32'h8001);
    applyStimulus("F_R", 1'b1, 16'h1F2E, 32, 16'h0F0F, -1, 16'h0);
    checkOutput("F_en_temp", {16'b0, enTemp}, 32'h1F2E);
    checkOutput("F_pulse", rxPulses, p0 + 5);

    // LRCK stuck high for 40 BCLKs: the word still completes, then one error at rise 32.
    $display("[TB] stuck lrck");
    e0 = errPulses;
    applyStimulus("G_L", 1'b0, 16'h1234, 32, 16'h0F0F, -1, 16'h0);
    applyStimulus("G_R", 1'b1, 16'h8001, 40, 16'h0F0F, -1, 16'h0);
    checkOutput("G_err_rise31", errAtRise[31], e0);
    checkOutput("G_err_rise32", errAtRise[32], e0 + 1);
    checkOutput("G_err_rise39", errAtRise[39], e0 + 1);
    checkOutput("G_en_temp", {16'b0, enTemp}, 32'h8001);
    checkOutput("G_pulse", rxPulses, p0 + 6);
    applyStimulus("H_L", 1'b0, 16'h1234, 32, 16'h0F0F, -1, 16'h0);
    checkOutput("H_left_no_pulse", rxPulses, p0 + 6);
    applyStimulus("H_R", 1'b1, 16'h2468, 32, 16'h0F0F, -1, 16'h0);
    checkOutput("H_en_temp", {16'b0, enTemp}, 32'h2468);
    checkOutput("H_pulse", rxPulses, p0 + 7);
    checkOutput("H_no_new_err", errPulses, e0 + 1);

    // Reset in the middle of a right word: outputs clear at once, the partial word is lost.
    $display("[TB] reset mid-word");
    applyStimulus("I_L", 1'b0, 16'h1234, 32, 16'h0F0F, -1, 16'h0);
    applyStimulus("I_R", 1'b1, 16'h7777, 9, 16'h0F0F, -1, 16'h0);
    checkOutput("I_dac_before_rst", {31'b0, dacDat}, 32'h1);
    checkOutput("I_en_temp_before_rst", {16'b0, enTemp}, 32'h2468);
    rst_n = 1'b0;
    #1;
    checkOutput("I_rst_en_temp", {16'b0, enTemp}, 32'h0);
    checkOutput("I_rst_rx_down", {31'b0, audioRxDown}, 32'h0);
    checkOutput("I_rst_frame_err", {31'b0, frameErr}, 32'h0);
    checkOutput("I_rst_dac", {31'b0, dacDat}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    p0 = rxPulses;
    applyStimulus("J_RC", 1'b1, 16'h0000, 23, 16'h0000, -1, 16'h0);
    checkOutput("J_cont_no_pulse", rxPulses, p0);
    applyStimulus("J_L", 1'b0, 16'h1234, 32, 16'h0F0F, -1, 16'h0);
    checkOutput("J_left_no_pulse", rxPulses, p0);
    applyStimulus("J_R", 1'b1, 16'h4321, 32, 16'h0F0F, -1, 16'h0);
    checkOutput("J_en_temp", {16'b0, enTemp}, 32'h4321);
    checkOutput("J_pulse", rxPulses, p0 + 1);

    // Strobe hygiene over the whole run.
    checkOutput("total_frame_err", errPulses, 2);
    checkOutput("rx_down_width", rxHigh, rxPulses);
    checkOutput("frame_err_width", errHigh, errPulses);
    checkOutput("strobe_collision", collide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
